// File: rtl/mash_dsm_divctl.sv
// Third-order MASH 1-1-1 delta-sigma modulator producing the per-cycle DIVNUM word for the divider.
// Optional LFSR dither on the first-stage carry-in: define MASH_DSM_DITHER_EN.
module mash_dsm_divctl #(
  parameter int FRAC_W   = 24,
  parameter int OUT_W    = 7,
  parameter int DIV_MIN  = 4,
  parameter int DIV_MAX  = 127,
  parameter int NINT_RST = 32
) (
  input  logic              CKVD,
  input  logic              RST,
  input  logic              EN,
  input  logic              LOAD,
  input  logic [OUT_W-1:0]  NINT,
  input  logic [FRAC_W-1:0] FRAC,
  input  logic [1:0]        ORDER,
  output logic [OUT_W-1:0]  DIVNUM,
  output logic              SAT
);

  localparam int TW = OUT_W + 2;
  localparam logic signed [TW-1:0] T_MIN = TW'(DIV_MIN);
  localparam logic signed [TW-1:0] T_MAX = TW'(DIV_MAX);

  logic [OUT_W-1:0]  r_nint_s;
  logic [FRAC_W-1:0] r_frac_s;
  logic [1:0]        r_ord_s;

  logic [FRAC_W-1:0] r_acc1_p0, r_acc2_p0, r_acc3_p0;
  logic              r_c2d_p0, r_c3d_p0, r_c3dd_p0;

  logic [OUT_W-1:0]  r_divnum_p1;
  logic              r_sat_p1;

  logic              w_cin;
  logic              w_st1, w_st2, w_st3;
  logic [FRAC_W:0]   w_s1, w_s2, w_s3;
  logic              w_c1, w_c2, w_c3;
  logic signed [3:0] w_y1, w_y2, w_y3, w_y;
  logic signed [TW-1:0] w_t_p0;
  logic              w_clr;

  function automatic logic [OUT_W-1:0] clamp_div(input logic signed [TW-1:0] t);
    if (t < T_MIN)      return T_MIN[OUT_W-1:0];
    else if (t > T_MAX) return T_MAX[OUT_W-1:0];
    else                return t[OUT_W-1:0];
  endfunction

  function automatic logic sat_flag(input logic signed [TW-1:0] t);
    return (t < T_MIN) || (t > T_MAX);
  endfunction

`ifdef MASH_DSM_DITHER_EN
  logic [22:0] r_lfsr;
  always_ff @(posedge CKVD) begin
    if (RST)     r_lfsr <= 23'h1;
    else if (EN) r_lfsr <= {r_lfsr[21:0], r_lfsr[22] ^ r_lfsr[17]};
  end
  assign w_cin = r_lfsr[0];
`else
  assign w_cin = 1'b0;
`endif

  // Stage p0: accumulator chain, gated stages contribute neither residue nor carry
  always_comb begin
    w_st1 = (r_ord_s >= 2'd1);
    w_st2 = (r_ord_s >= 2'd2);
    w_st3 = (r_ord_s == 2'd3);
    w_s1  = {1'b0, r_acc1_p0} + {1'b0, r_frac_s} + {{FRAC_W{1'b0}}, w_cin};
    w_s2  = {1'b0, r_acc2_p0} + {1'b0, w_s1[FRAC_W-1:0]};
    w_s3  = {1'b0, r_acc3_p0} + {1'b0, w_s2[FRAC_W-1:0]};
    w_c1  = w_st1 & w_s1[FRAC_W];
    w_c2  = w_st2 & w_s2[FRAC_W];
    w_c3  = w_st3 & w_s3[FRAC_W];
  end

  always_comb begin
    w_y1 = $signed({3'b000, w_c1});
    w_y2 = w_y1 + $signed({3'b000, w_c2}) - $signed({3'b000, r_c2d_p0});
    w_y3 = w_y2 + $signed({3'b000, w_c3}) - $signed({2'b00, r_c3d_p0, 1'b0})
         + $signed({3'b000, r_c3dd_p0});
    w_y  = 4'sd0;
    if (EN) begin
      case (r_ord_s)
        2'd1:    w_y = w_y1;
        2'd2:    w_y = w_y2;
        2'd3:    w_y = w_y3;
        default: w_y = 4'sd0;
      endcase
    end
    w_t_p0 = $signed({2'b00, r_nint_s}) + $signed({{(TW-4){w_y[3]}}, w_y});
  end

  assign w_clr = LOAD && (ORDER != r_ord_s);

  always_ff @(posedge CKVD) begin
    if (RST) begin
      r_nint_s <= OUT_W'(NINT_RST);
      r_frac_s <= '0;
      r_ord_s  <= 2'd3;
    end else if (LOAD) begin
      r_nint_s <= NINT;
      r_frac_s <= FRAC;
      r_ord_s  <= ORDER;
    end
  end

  // Order change flushes the whole chain on the capture edge so the new order starts clean
  always_ff @(posedge CKVD) begin
    if (RST || w_clr) begin
      r_acc1_p0 <= '0;
      r_acc2_p0 <= '0;
      r_acc3_p0 <= '0;
      r_c2d_p0  <= 1'b0;
      r_c3d_p0  <= 1'b0;
      r_c3dd_p0 <= 1'b0;
    end else if (EN) begin
      r_acc1_p0 <= w_st1 ? w_s1[FRAC_W-1:0] : '0;
      r_acc2_p0 <= w_st2 ? w_s2[FRAC_W-1:0] : '0;
      r_acc3_p0 <= w_st3 ? w_s3[FRAC_W-1:0] : '0;
      r_c2d_p0  <= w_c2;
      r_c3d_p0  <= w_c3;
      r_c3dd_p0 <= r_c3d_p0;
    end
  end

  // Stage p1: clamped, registered division ratio
  always_ff @(posedge CKVD) begin
    if (RST) begin
      r_divnum_p1 <= OUT_W'(NINT_RST);
      r_sat_p1    <= 1'b0;
    end else begin
      r_divnum_p1 <= clamp_div(w_t_p0);
      r_sat_p1    <= sat_flag(w_t_p0);
    end
  end

  assign DIVNUM = r_divnum_p1;
  assign SAT    = r_sat_p1;

endmodule

// File: doc/mash_dsm_divctl.md
Name: mash_dsm_divctl

Overview:
- Third-order MASH 1-1-1 delta-sigma modulator that generates the per-cycle division ratio for the multi-modulus divider in the fractional-N loop.
- Clocked by the divided clock CKVD. On every CKVD cycle it produces a new DIVNUM word whose long-run average equals NINT + FRAC/2^FRAC_W.
- It is the producer on the DIVNUM interface; the divider consumes that word.

Parameters:
- FRAC_W, 24, fractional word width; accumulator width.
- OUT_W, 7, DIVNUM width; must match the divider's DIVNUM width.
- DIV_MIN, 4, smallest legal DIVNUM; the output is clamped to it.
- DIV_MAX, 127, largest legal DIVNUM; the output is clamped to it.
- NINT_RST, 32, reset value of the integer shadow register and of DIVNUM.

Ports:
- CKVD, input, 1, divided clock; all logic is on its rising edge.
- RST, input, 1, synchronous reset, active-high.
- EN, input, 1, modulator enable. Low selects integer mode.
- LOAD, input, 1, single-cycle strobe that captures NINT, FRAC and ORDER into shadow registers.
- NINT, input, OUT_W, integer part of the division ratio.
- FRAC, input, FRAC_W, fractional part of the division ratio (unsigned).
- ORDER, input, 2, modulator order. 0 = integer only, 1/2/3 = MASH order.
- DIVNUM, output, OUT_W, registered division ratio driven to the divider.
- SAT, output, 1, registered flag, high in any cycle where DIVNUM was clamped.

Behaviour:
- Reset (RST high at a CKVD edge):
  - Accumulators acc1, acc2, acc3 = 0; carry delay registers = 0.
  - Shadows: nint_s = NINT_RST, frac_s = 0, ord_s = 3.
  - DIVNUM = NINT_RST, SAT = 0.
  - RST takes priority over LOAD and EN.
  - A reset mid-sequence discards all accumulator state with no residue.
- Shadow load:
  - LOAD high captures the inputs at that edge.
  - The new values first affect the accumulators and DIVNUM at the following edge (latency 1).
  - If the captured ORDER differs from ord_s, all accumulators and delay registers clear on that same capture edge.
  - If the order is unchanged, accumulators continue (phase-continuous frequency step).
- Accumulator chain (all FRAC_W-bit, unsigned, wrap modulo 2^FRAC_W), evaluated combinationally within one cycle:
  - s1 = acc1 + frac_s, c1 = carry out.
  - s2 = acc2 + s1[FRAC_W-1:0], c2 = carry out.
  - s3 = acc3 + s2[FRAC_W-1:0], c3 = carry out.
  - Each accumulator registers its own residue.
- Stages above ord_s are held at 0 and contribute no carries.
- Noise cancellation (signed, minimum 4 bits). Registered delays: c2d = c2[n-1], c3d = c3[n-1], c3dd = c3[n-2].
  - Order 1: y = c1. Range 0..1.
  - Order 2: y = c1 + c2 − c2d. Range −1..2.
  - Order 3: y = c1 + c2 − c2d + c3 − 2·c3d + c3dd. Range −3..4.
  - Order 0: y = 0.
- Output:
  - t = nint_s + y, computed signed at OUT_W+2 bits.
  - DIVNUM <= clamp(t, DIV_MIN, DIV_MAX), registered with 1-cycle latency.
  - SAT <= (t < DIV_MIN) or (t > DIV_MAX).
- EN low:
  - Accumulators and delay registers hold their values.
  - DIVNUM <= clamp(nint_s), SAT computed the same way.
  - When EN rises, operation resumes from the held state.
- Simultaneous LOAD and EN low: the shadows still capture; DIVNUM follows the new nint_s from the next edge.
- FRAC = 0 with any order: y is 0 forever after the clear, so DIVNUM = nint_s constantly.

Optional Feature:
- Macro: MASH_DSM_DITHER_EN.
- Defined:
  - A 23-bit Fibonacci LFSR (x^23 + x^18 + 1, seed 23'h1, reset on RST) advances every cycle while EN is high.
  - Its bit 0 is added as carry-in into s1, breaking idle tones.
  - The average ratio error is bounded by 2^−(FRAC_W+1).
- Undefined: no LFSR is present and the carry-in is 0, so the output is fully deterministic. The Test Plan exact-average checks require this build.

Test Plan:
- Reset: assert RST for 2 cycles -> DIVNUM = 32, SAT = 0 on the first edge after reset. No X on any output.
- Integer mode: LOAD NINT = 40, FRAC = 0, ORDER = 3, EN = 1 -> DIVNUM = 40 from the second edge onward, constant for 1000 cycles, SAT = 0.
- First order: LOAD NINT = 40, FRAC = 2^23, ORDER = 1 -> DIVNUM alternates 40/41, starting at 40 two edges after LOAD. Sum over 1024 cycles = 41472 exactly.
- Third order: LOAD NINT = 40, FRAC = 2^22, ORDER = 3 -> over 4096 cycles DIVNUM stays in 37..44, sum = 164864 exactly (average 40.25), SAT = 0.
- Clamp: LOAD NINT = 5, FRAC = 2^22, ORDER = 3 -> DIVNUM never below 4; SAT high in exactly the cycles where the unclamped value is 2 or 3, checked against a reference model.
- Mid-run events:
  - Order change: ORDER 3 to 2 with LOAD -> accumulators clear and the next output equals a fresh order-2 sequence.
  - EN low for 10 cycles -> DIVNUM = NINT, then the sequence resumes from the held state.
  - RST pulse mid-run -> DIVNUM = 32 on the next edge.
